mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_arb_grant.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and sizing for the fetch/data memory-port arbiter.
// Holds the arbiter state encoding and the starvation-counter width helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  localparam int unsigned STARVE_MAX_DEF = 3;

  // Width needed to hold 0..smax; at least one bit so a zero limit still elaborates.
  function automatic int unsigned starve_cnt_w(input int unsigned smax);
    return (smax < 1) ? 1 : $clog2(smax + 1);
  endfunction

  localparam int unsigned STARVE_CNT_W = starve_cnt_w(STARVE_MAX_DEF);

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between fetch and data ports with a starvation counter.
// Data wins ties until fetch has waited through STARVE_MAX data grants.
module mem_arb_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic idle_i,
  input  logic if_elig_i,
  input  logic dm_elig_i,
  input  logic if_req_i,
  output logic grant_if_o,
  output logic grant_dm_o
);

  localparam int unsigned CNT_W = starve_cnt_w(STARVE_MAX);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             at_max;

  assign at_max = (starve_q == CNT_W'(STARVE_MAX));

  always_comb begin
    grant_if_o = 1'b0;
    grant_dm_o = 1'b0;
    if (idle_i) begin
      if (dm_elig_i && !(if_elig_i && at_max)) begin
        grant_dm_o = 1'b1;
      end else if (if_elig_i) begin
        grant_if_o = 1'b1;
      end
    end
  end

  // Only data grants made while fetch is asking count toward starvation.
  always_comb begin
    starve_d = starve_q;
    if (grant_if_o) begin
      starve_d = '0;
    end else if (grant_dm_o) begin
      if (!if_req_i) begin
        starve_d = '0;
      end else if (!at_max) begin
        starve_d = starve_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory port.
// Single outstanding access; every grant is followed by at least one IDLE cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned MEM_ADDR_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [MEM_ADDR_W-1:0] if_addr_i,
  output logic [31:0]           if_rdata_o,
  output logic                  if_ack_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [MEM_ADDR_W-1:0] dm_addr_i,
  input  logic [31:0]           dm_wdata_i,
  output logic [31:0]           dm_rdata_o,
  output logic                  dm_ack_o,
  output logic                  if_stall_o,
  output logic                  dm_stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_ready_i
);

  localparam logic [MEM_ADDR_W-1:0] WORD_MASK = ~MEM_ADDR_W'(3);

  arb_state_e            state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [31:0]           if_rdata_q, if_rdata_d;
  logic [31:0]           dm_rdata_q, dm_rdata_d;
  logic                  if_ack_q, if_ack_d;
  logic                  dm_ack_q, dm_ack_d;
  logic                  idle, if_elig, dm_elig, grant_if, grant_dm;

  // A port is not eligible in its own ack cycle, so a held request is not re-served.
  assign idle    = (state_q == ST_IDLE);
  assign if_elig = if_req_i & ~if_ack_q;
  assign dm_elig = dm_req_i & ~dm_ack_q;

  mem_arb_grant #(
    .STARVE_MAX (STARVE_MAX)
  ) u_grant (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idle_i     (idle),
    .if_elig_i  (if_elig),
    .dm_elig_i  (dm_elig),
    .if_req_i   (if_req_i),
    .grant_if_o (grant_if),
    .grant_dm_o (grant_dm)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_dm) begin
          state_d     = ST_BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i & WORD_MASK;
          mem_wdata_d = dm_wdata_i;
        end else if (grant_if) begin
          state_d    = ST_BUSY_I;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr_i & WORD_MASK;
        end
      end
      ST_BUSY_I: begin
        if (mem_ready_i) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata_i;
          if_ack_d   = 1'b1;
        end
      end
      ST_BUSY_D: begin
        if (mem_ready_i) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          dm_ack_d  = 1'b1;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata_i;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_stall_o  = if_req_i & ~if_ack_q;
  assign dm_stall_o  = dm_req_i & ~dm_ack_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: grant-unit table, directed port
// transactions, multi-cycle corner cases and a randomized run against a model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int SM = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i, dm_req_i, dm_we_i, mem_ready_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_ack_o, dm_ack_o, if_stall_o, dm_stall_o, mem_req_o, mem_we_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.STARVE_MAX(SM), .MEM_ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .if_stall_o(if_stall_o), .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
  );

  // Standalone grant unit so the starvation limit can be driven directly.
  logic g_rst, g_idle, g_if_el, g_dm_el, g_if_req, g_gnt_if, g_gnt_dm;
  mem_arb_grant #(.STARVE_MAX(SM)) u_grant_unit (
    .clk_i(clk_i), .rst_i(g_rst), .idle_i(g_idle), .if_elig_i(g_if_el),
    .dm_elig_i(g_dm_el), .if_req_i(g_if_req), .grant_if_o(g_gnt_if), .grant_dm_o(g_gnt_dm)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Transaction-level reference: which port owns the memory (0 none, 1 fetch, 2 data).
  int          m_port = 0, m_starve = 0;
  logic        m_req = 0, m_we = 0, m_ack_if = 0, m_ack_dm = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_if_rd = 0, m_dm_rd = 0;

  task automatic model_step();
    logic if_el, dm_el, a_if, a_dm;
    a_if = 1'b0;
    a_dm = 1'b0;
    if (rst_i) begin
      m_port = 0; m_starve = 0; m_req = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_if_rd = 0; m_dm_rd = 0;
    end else if (m_port == 0) begin
      if_el = if_req_i && !m_ack_if;
      dm_el = dm_req_i && !m_ack_dm;
      if (dm_el && !(if_el && m_starve == SM)) begin
        m_port = 2; m_req = 1; m_we = dm_we_i;
        m_addr = dm_addr_i & 32'hFFFF_FFFC; m_wdata = dm_wdata_i;
        m_starve = if_req_i ? ((m_starve < SM) ? m_starve + 1 : SM) : 0;
      end else if (if_el) begin
        m_port = 1; m_req = 1; m_we = 0;
        m_addr = if_addr_i & 32'hFFFF_FFFC;
        m_starve = 0;
      end
    end else if (mem_ready_i) begin
      if (m_port == 1) begin
        m_if_rd = mem_rdata_i; a_if = 1'b1;
      end else begin
        if (!m_we) m_dm_rd = mem_rdata_i;
        a_dm = 1'b1;
      end
      m_port = 0; m_req = 0;
    end
    m_ack_if = a_if;
    m_ack_dm = a_dm;
  endtask

  // Memory responder: ready once mem_req_o has been high for the chosen latency.
  int busy_cnt = 0, cur_lat = 1, lat_fix = 0;

  task automatic respond();
    if (mem_req_o) begin
      busy_cnt++;
      if (busy_cnt == 1) cur_lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
      if (busy_cnt >= cur_lat) begin
        mem_ready_i = 1'b1; mem_rdata_i = mem_word(mem_addr_o);
      end else begin
        mem_ready_i = 1'b0; mem_rdata_i = $urandom;
      end
    end else begin
      busy_cnt = 0;
      mem_ready_i = 1'($urandom_range(0, 1));
      mem_rdata_i = $urandom;
    end
  endtask

  task automatic cycle();
    @(negedge clk_i);
    model_step();
    @(posedge clk_i);
    #1;
    chk("cyc_mem", 128'({mem_req_o, mem_we_o & mem_req_o, mem_addr_o, mem_wdata_o}),
        128'({m_req, m_we & m_req, m_addr, m_wdata}));
    chk("cyc_port", 128'({if_ack_o, dm_ack_o, if_rdata_o, dm_rdata_o, if_stall_o, dm_stall_o}),
        128'({m_ack_if, m_ack_dm, m_if_rd, m_dm_rd, if_req_i & ~m_ack_if, dm_req_i & ~m_ack_dm}));
    respond();
  endtask

  typedef struct {
    bit          idle, if_el, dm_el, if_req, exp_dm, exp_if;
  } gvec_t;

  typedef struct {
    bit          is_fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_addr;
    int          exp_ack_at;
    logic [31:0] exp_rdata;
  } vec_t;

  gvec_t gv[14];
  vec_t  vecs[6];

  initial begin
    int          n;
    bit          got, seen, stable, ok;
    logic [31:0] a0, w0;
    logic        we0;
    bit          if_act, dm_act;

    // idle, if_el, dm_el, if_req -> expected dm grant, fetch grant
    gv[0]  = '{1,1,1,1, 1,0};  gv[1]  = '{1,1,1,1, 1,0};  gv[2]  = '{1,1,1,1, 1,0};
    gv[3]  = '{1,1,1,1, 0,1};  gv[4]  = '{1,1,1,1, 1,0};  gv[5]  = '{1,1,1,1, 1,0};
    gv[6]  = '{1,0,1,0, 1,0};  gv[7]  = '{1,1,1,1, 1,0};  gv[8]  = '{1,1,1,1, 1,0};
    gv[9]  = '{0,1,1,1, 0,0};  gv[10] = '{1,1,1,1, 1,0};  gv[11] = '{1,1,1,1, 0,1};
    gv[12] = '{1,0,0,1, 0,0};  gv[13] = '{1,1,0,1, 0,1};

    vecs[0] = '{1, 0, 32'h0000_0008, 32'h0,         2, 32'h0000_0008, 3, 32'h5A5A_0008};
    vecs[1] = '{0, 0, 32'h0000_0013, 32'h0,         1, 32'h0000_0010, 2, 32'h5A5A_0010};
    vecs[2] = '{0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 1, 32'h0000_0010, 2, 32'h5A5A_0010};
    vecs[3] = '{0, 0, 32'h0000_0100, 32'h0,         6, 32'h0000_0100, 7, 32'h5A5A_0100};
    vecs[4] = '{1, 0, 32'hFFFF_FFFE, 32'h0,         3, 32'hFFFF_FFFC, 4, 32'hA5A5_FFFC};
    vecs[5] = '{0, 1, 32'h0000_0007, 32'h1234_5678, 4, 32'h0000_0004, 5, 32'h5A5A_0100};

    rst_i = 1; if_req_i = 0; dm_req_i = 0; dm_we_i = 0;
    if_addr_i = 0; dm_addr_i = 0; dm_wdata_i = 0; mem_ready_i = 0; mem_rdata_i = 0;
    g_rst = 1; g_idle = 0; g_if_el = 0; g_dm_el = 0; g_if_req = 0;

    // Grant unit: three starving data grants, then fetch wins, then the count restarts.
    @(posedge clk_i); #1;
    g_rst = 0;
    for (int i = 0; i < 14; i++) begin
      g_idle = gv[i].idle; g_if_el = gv[i].if_el; g_dm_el = gv[i].dm_el; g_if_req = gv[i].if_req;
      #1;
      chk($sformatf("grant_step%0d", i), 128'({g_gnt_dm, g_gnt_if}), 128'({gv[i].exp_dm, gv[i].exp_if}));
      @(posedge clk_i); #1;
    end

    repeat (2) cycle();
    chk("reset_outputs", 128'({mem_req_o, mem_we_o, if_ack_o, dm_ack_o, mem_addr_o,
                               mem_wdata_o, if_rdata_o, dm_rdata_o}), 128'(0));
    rst_i = 0;
    cycle();

    // Single transactions from a table.
    for (int i = 0; i < 6; i++) begin
      lat_fix = vecs[i].lat;
      if (vecs[i].is_fetch) begin
        if_req_i = 1; if_addr_i = vecs[i].addr;
      end else begin
        dm_req_i = 1; dm_we_i = vecs[i].we; dm_addr_i = vecs[i].addr; dm_wdata_i = vecs[i].wdata;
      end
      n = 0; got = 0; seen = 0; stable = 1; a0 = 0; w0 = 0; we0 = 0;
      while (!got && n < 30) begin
        cycle();
        n++;
        if (mem_req_o) begin
          if (!seen) begin
            seen = 1; a0 = mem_addr_o; w0 = mem_wdata_o; we0 = mem_we_o;
          end else if (mem_addr_o !== a0 || mem_wdata_o !== w0 || mem_we_o !== we0) begin
            stable = 0;
          end
        end
        got = vecs[i].is_fetch ? if_ack_o : dm_ack_o;
      end
      if_req_i = 0; dm_req_i = 0;
      chk($sformatf("vec%0d_ack_at", i), 128'(n), 128'(vecs[i].exp_ack_at));
      chk($sformatf("vec%0d_addr", i), 128'(a0), 128'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_we", i), 128'(we0), 128'(vecs[i].we));
      chk($sformatf("vec%0d_stable", i), 128'(stable), 128'(1));
      chk($sformatf("vec%0d_rdata", i), 128'(vecs[i].is_fetch ? if_rdata_o : dm_rdata_o),
          128'(vecs[i].exp_rdata));
      if (vecs[i].we) chk($sformatf("vec%0d_wdata", i), 128'(w0), 128'(vecs[i].wdata));
      cycle();
    end

    // Simultaneous fetch and store: store first, fetch in the ack cycle of the store.
    lat_fix = 1;
    if_req_i = 1; if_addr_i = 32'h20;
    dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h10; dm_wdata_i = 32'hDEAD_BEEF;
    cycle();
    chk("sim_store_first", 128'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}),
        128'({1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF}));
    ok = 1; n = 0;
    while (!dm_ack_o && n < 10) begin
      if (!if_stall_o) ok = 0;
      cycle(); n++;
    end
    chk("sim_dm_ack", 128'(dm_ack_o), 128'(1));
    dm_req_i = 0;
    cycle();
    chk("sim_fetch_grant", 128'({mem_req_o, mem_we_o, mem_addr_o}), 128'({1'b1, 1'b0, 32'h20}));
    n = 0;
    while (!if_ack_o && n < 10) begin
      if (!if_stall_o) ok = 0;
      cycle(); n++;
    end
    chk("sim_if_stall_held", 128'(ok), 128'(1));
    chk("sim_if_rdata", 128'({if_ack_o, if_rdata_o}), 128'({1'b1, 32'h5A5A_0020}));
    if_req_i = 0;
    cycle();

    // Reset in the middle of a data access abandons it.
    lat_fix = 8;
    dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h200;
    repeat (3) cycle();
    chk("rst_busy_before", 128'(mem_req_o), 128'(1));
    rst_i = 1;
    cycle();
    chk("rst_mid_busy", 128'({mem_req_o, dm_ack_o, dm_rdata_o}), 128'(0));
    rst_i = 0; dm_req_i = 0;
    got = 0;
    repeat (10) begin
      cycle();
      if (dm_ack_o) got = 1;
    end
    chk("rst_no_ack", 128'(got), 128'(0));
    lat_fix = 1;
    dm_req_i = 1; dm_addr_i = 32'h204;
    n = 0;
    while (!dm_ack_o && n < 10) begin
      cycle(); n++;
    end
    chk("rst_then_load", 128'({dm_ack_o, dm_rdata_o}), 128'({1'b1, 32'h5A5A_0204}));
    dm_req_i = 0;
    cycle();

    // Randomized traffic, including requesters that give up mid-access.
    lat_fix = 0; if_act = 0; dm_act = 0;
    repeat (2000) begin
      cycle();
      if (if_ack_o) if_act = 0;
      if (dm_ack_o) dm_act = 0;
      if (if_act && $urandom_range(0, 49) == 0) if_act = 0;
      if (dm_act && $urandom_range(0, 49) == 0) dm_act = 0;
      if (!if_act && $urandom_range(0, 2) == 0) begin
        if_act = 1; if_addr_i = $urandom;
      end
      if (!dm_act && $urandom_range(0, 2) == 0) begin
        dm_act = 1; dm_we_i = 1'($urandom); dm_addr_i = $urandom; dm_wdata_i = $urandom;
      end
      if_req_i = if_act; dm_req_i = dm_act;
    end
    if_req_i = 0; dm_req_i = 0;
    repeat (8) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
